// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice: opcodes, funct codes,
// ALU-op classes, 4-bit ALU control values and the decoded control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSV   = 2'b11;

    localparam logic [3:0] ALUCTL_AND = 4'b0000;
    localparam logic [3:0] ALUCTL_OR  = 4'b0001;
    localparam logic [3:0] ALUCTL_ADD = 4'b0010;
    localparam logic [3:0] ALUCTL_SUB = 4'b0110;
    localparam logic [3:0] ALUCTL_SLT = 4'b0111;
    localparam logic [3:0] ALUCTL_NOR = 4'b1100;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU of the execute slice. The nor operation exists only when
// EXEC_NOR_EN is defined; otherwise its control code produces zero.
module alu_core
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   ctl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] out,
    output logic         zero
);

    always_comb begin
        out = '0;
        case (ctl)
            ALUCTL_AND: out = a & b;
            ALUCTL_OR:  out = a | b;
            ALUCTL_ADD: out = a + b;
            ALUCTL_SUB: out = a - b;
            ALUCTL_SLT: out = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef EXEC_NOR_EN
            ALUCTL_NOR: out = ~(a | b);
`else
            ALUCTL_NOR: out = '0;
`endif
            default:    out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/mips_exec_slice.sv
// Decode + execute slice: main decode, ALU control, B-operand mux and the
// EX/MEM output register. EXEC_NOR_EN enables the R-type nor instruction.
module mips_exec_slice
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [31:0]  instr,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    output logic [3:0]   aluctl,
    output logic [W-1:0] alu_b,
    output logic         regdst,
    output logic         branch,
    output logic         memread,
    output logic         memwrite,
    output logic         memtoreg,
    output logic         regwrite,
    output logic         alusrc,
    output logic [1:0]   aluop,
    output logic         out_valid,
    output logic [W-1:0] result_q,
    output logic         zero_q,
    output logic         regwrite_q,
    output logic         memtoreg_q,
    output logic         memread_q,
    output logic         memwrite_q,
    output logic         branch_q
);

    logic [5:0]   opcode;
    logic [5:0]   funct;
    logic [W-1:0] imm_ext;
    ctrl_t        ctrl;
    logic [W-1:0] alu_out;
    logic         alu_zero;
    logic         unused_instr_bits;

    assign opcode  = instr[31:26];
    assign funct   = instr[5:0];
    assign imm_ext = {{(W-16){instr[15]}}, instr[15:0]};
    // Register specifiers are consumed by the register file, not here.
    assign unused_instr_bits = ^instr[25:16];

    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: ctrl = ctrl_t'({7'b1001000, ALUOP_FUNCT});
            OP_LW:    ctrl = ctrl_t'({7'b0111100, ALUOP_ADD});
            OP_SW:    ctrl = ctrl_t'({7'b0100010, ALUOP_ADD});
            OP_BEQ:   ctrl = ctrl_t'({7'b0000001, ALUOP_SUB});
            OP_ADDI:  ctrl = ctrl_t'({7'b0101000, ALUOP_ADD});
            default:  ctrl = '0;
        endcase
    end

    assign regdst   = ctrl.regdst;
    assign alusrc   = ctrl.alusrc;
    assign memtoreg = ctrl.memtoreg;
    assign regwrite = ctrl.regwrite;
    assign memread  = ctrl.memread;
    assign memwrite = ctrl.memwrite;
    assign branch   = ctrl.branch;
    assign aluop    = ctrl.aluop;

    always_comb begin
        aluctl = ALUCTL_ADD;
        case (ctrl.aluop)
            ALUOP_ADD: aluctl = ALUCTL_ADD;
            ALUOP_SUB: aluctl = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  aluctl = ALUCTL_ADD;
                    FN_SUB:  aluctl = ALUCTL_SUB;
                    FN_AND:  aluctl = ALUCTL_AND;
                    FN_OR:   aluctl = ALUCTL_OR;
                    FN_SLT:  aluctl = ALUCTL_SLT;
`ifdef EXEC_NOR_EN
                    FN_NOR:  aluctl = ALUCTL_NOR;
`else
                    FN_NOR:  aluctl = ALUCTL_ADD;
`endif
                    default: aluctl = ALUCTL_ADD;
                endcase
            end
            ALUOP_RSV: aluctl = ALUCTL_ADD;
            default:   aluctl = ALUCTL_ADD;
        endcase
    end

    assign alu_b = ctrl.alusrc ? imm_ext : rt_data;

    alu_core #(.W(W)) u_alu (
        .ctl  (aluctl),
        .a    (rs_data),
        .b    (alu_b),
        .out  (alu_out),
        .zero (alu_zero)
    );

    logic         out_valid_d, out_valid_q;
    logic [W-1:0] result_d;
    logic         zero_d;
    logic         regwrite_d, memtoreg_d, memread_d, memwrite_d, branch_d;

    // Bubbles squash the controls but the datapath still captures its value.
    always_comb begin
        out_valid_d = in_valid;
        result_d    = alu_out;
        zero_d      = alu_zero;
        regwrite_d  = in_valid & ctrl.regwrite;
        memtoreg_d  = in_valid & ctrl.memtoreg;
        memread_d   = in_valid & ctrl.memread;
        memwrite_d  = in_valid & ctrl.memwrite;
        branch_d    = in_valid & ctrl.branch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            branch_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            memread_q   <= memread_d;
            memwrite_q  <= memwrite_d;
            branch_q    <= branch_d;
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mips_exec_slice.sv
// Self-checking bench for mips_exec_slice: instruction-level model plus
// directed vectors with literal expectations. Honours EXEC_NOR_EN.
module tb_mips_exec_slice;

    localparam int W = 32;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  instr    = '0;
    logic [W-1:0] rs_data  = '0;
    logic [W-1:0] rt_data  = '0;

    logic [3:0]   aluctl;
    logic [W-1:0] alu_b;
    logic         regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
    logic [1:0]   aluop;
    logic         out_valid;
    logic [W-1:0] result_q;
    logic         zero_q, regwrite_q, memtoreg_q, memread_q, memwrite_q, branch_q;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] result;
        logic         zero;
        logic         regwrite;
        logic         memtoreg;
        logic         memread;
        logic         memwrite;
        logic         branch;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 1'b0;

    mips_exec_slice #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .aluctl     (aluctl),
        .alu_b      (alu_b),
        .regdst     (regdst),
        .branch     (branch),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrc     (alusrc),
        .aluop      (aluop),
        .out_valid  (out_valid),
        .result_q   (result_q),
        .zero_q     (zero_q),
        .regwrite_q (regwrite_q),
        .memtoreg_q (memtoreg_q),
        .memread_q  (memread_q),
        .memwrite_q (memwrite_q),
        .branch_q   (branch_q)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [W-1:0] sext(input logic [15:0] imm);
        return {{(W-16){imm[15]}}, imm};
    endfunction

    // {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}
    function automatic logic [8:0] model_decode(input logic [5:0] op);
        case (op)
            6'b000000: return 9'b1_0_0_1_0_0_0_10;
            6'b100011: return 9'b0_1_1_1_1_0_0_00;
            6'b101011: return 9'b0_1_0_0_0_1_0_00;
            6'b000100: return 9'b0_0_0_0_0_0_1_01;
            6'b001000: return 9'b0_1_0_1_0_0_0_00;
            default:   return 9'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_aluctl(input logic [31:0] i);
        if (i[31:26] == 6'b000100) return 4'b0110;
        if (i[31:26] != 6'b000000) return 4'b0010;
        case (i[5:0])
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
`ifdef EXEC_NOR_EN
            6'b100111: return 4'b1100;
`endif
            default:   return 4'b0010;
        endcase
    endfunction

    function automatic logic [W-1:0] model_alub(input logic [31:0] i, input logic [W-1:0] rt);
        case (i[31:26])
            6'b100011, 6'b101011, 6'b001000: return sext(i[15:0]);
            default: return rt;
        endcase
    endfunction

    // What each instruction computes, stated per instruction.
    function automatic logic [W-1:0] model_result(input logic [31:0] i,
                                                  input logic [W-1:0] rs,
                                                  input logic [W-1:0] rt);
        case (i[31:26])
            6'b100011, 6'b101011, 6'b001000: return rs + sext(i[15:0]);
            6'b000100: return rs - rt;
            6'b000000: begin
                case (i[5:0])
                    6'b100010: return rs - rt;
                    6'b100100: return rs & rt;
                    6'b100101: return rs | rt;
                    6'b101010: return ($signed(rs) < $signed(rt)) ? W'(1) : W'(0);
`ifdef EXEC_NOR_EN
                    6'b100111: return ~(rs | rt);
`endif
                    default:   return rs + rt;
                endcase
            end
            default: return rs + rt;
        endcase
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(posedge clk) begin : push_blk
        exp_t       e;
        logic [8:0] d;
        e = '0;
        if (!reset) begin
            d          = model_decode(instr[31:26]);
            e.valid    = in_valid;
            e.result   = model_result(instr, rs_data, rt_data);
            e.zero     = (e.result == '0);
            e.regwrite = in_valid & d[5];
            e.memtoreg = in_valid & d[6];
            e.memread  = in_valid & d[4];
            e.memwrite = in_valid & d[3];
            e.branch   = in_valid & d[2];
        end
        exp_q.push_back(e);
    end

    always @(posedge reset) begin
        if (started) begin
            exp_q.delete();
            exp_q.push_back('0);
        end
    end

    always @(negedge clk) begin : cmp_blk
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid",  W'(out_valid),  W'(e.valid));
            check("result_q",   result_q,       e.result);
            check("zero_q",     W'(zero_q),     W'(e.zero));
            check("regwrite_q", W'(regwrite_q), W'(e.regwrite));
            check("memtoreg_q", W'(memtoreg_q), W'(e.memtoreg));
            check("memread_q",  W'(memread_q),  W'(e.memread));
            check("memwrite_q", W'(memwrite_q), W'(e.memwrite));
            check("branch_q",   W'(branch_q),   W'(e.branch));
        end
        check("decode", W'({regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}),
              W'(model_decode(instr[31:26])));
        check("aluctl", W'(aluctl), W'(model_aluctl(instr)));
        check("alu_b",  alu_b,      model_alub(instr, rt_data));
    end

    // ---------------- driver ----------------
    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'b000000, 20'h0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 10'h0, imm};
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #2;
        in_valid = v;
        instr    = i;
        rs_data  = a;
        rt_data  = b;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  tbl_instr [7];
    logic [W-1:0] tbl_rs    [7];
    logic [W-1:0] tbl_rt    [7];
    logic [W-1:0] tbl_res   [7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl_instr[0] = rtype(6'b100100);          tbl_rs[0] = 32'hF0F0; tbl_rt[0] = 32'hFF00;     tbl_res[0] = 32'hF000;
        tbl_instr[1] = rtype(6'b100101);          tbl_rs[1] = 32'hF0F0; tbl_rt[1] = 32'h0F0F;     tbl_res[1] = 32'hFFFF;
        tbl_instr[2] = itype(6'b101011, 16'h0008); tbl_rs[2] = 32'h10;  tbl_rt[2] = 32'h55;       tbl_res[2] = 32'h18;
        tbl_instr[3] = itype(6'b001000, 16'hFFFF); tbl_rs[3] = 32'h1;   tbl_rt[3] = 32'h0;        tbl_res[3] = 32'h0;
        tbl_instr[4] = rtype(6'b000000);          tbl_rs[4] = 32'h3;    tbl_rt[4] = 32'h4;        tbl_res[4] = 32'h7;
        tbl_instr[5] = rtype(6'b101010);          tbl_rs[5] = 32'h1;    tbl_rt[5] = 32'hFFFFFFFF; tbl_res[5] = 32'h0;
        tbl_instr[6] = rtype(6'b100010);          tbl_rs[6] = 32'h5;    tbl_rt[6] = 32'h7;        tbl_res[6] = 32'hFFFFFFFE;

        repeat (2) @(posedge clk);
        #1;
        check("rst_result_q", result_q, 32'h0);
        check("rst_out_valid", W'(out_valid), 32'h0);
        @(posedge clk);
        #2;
        reset   = 1'b0;
        started = 1'b1;

        drive(1'b1, rtype(6'b100000), 32'd5, 32'd7);
        #1;
        check("add_regdst", W'(regdst), 32'h1);
        check("add_aluctl", W'(aluctl), 32'h2);
        after_edge();
        check("add_result", result_q, 32'd12);
        check("add_zero", W'(zero_q), 32'h0);
        check("add_regwrite_q", W'(regwrite_q), 32'h1);
        check("add_out_valid", W'(out_valid), 32'h1);

        drive(1'b1, rtype(6'b100010), 32'h1234, 32'h1234);
        after_edge();
        check("sub_result", result_q, 32'h0);
        check("sub_zero", W'(zero_q), 32'h1);

        drive(1'b1, rtype(6'b101010), 32'hFFFFFFFF, 32'h1);
        after_edge();
        check("slt_result", result_q, 32'h1);

        drive(1'b1, itype(6'b100011, 16'hFFFC), 32'h100, 32'h0);
        #1;
        check("lw_alu_b", alu_b, 32'hFFFFFFFC);
        after_edge();
        check("lw_result", result_q, 32'hFC);
        check("lw_memread_q", W'(memread_q), 32'h1);
        check("lw_memtoreg_q", W'(memtoreg_q), 32'h1);
        check("lw_regwrite_q", W'(regwrite_q), 32'h1);

        drive(1'b1, itype(6'b000100, 16'h0010), 32'd9, 32'd9);
        #1;
        check("beq_aluctl", W'(aluctl), 32'h6);
        after_edge();
        check("beq_zero", W'(zero_q), 32'h1);
        check("beq_branch_q", W'(branch_q), 32'h1);

        drive(1'b1, itype(6'b111111, 16'h1234), 32'd1, 32'd2);
        #1;
        check("undef_decode", W'({regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}), 32'h0);

        drive(1'b0, rtype(6'b100000), 32'd5, 32'd7);
        after_edge();
        check("bubble_result", result_q, 32'd12);
        check("bubble_out_valid", W'(out_valid), 32'h0);
        check("bubble_regwrite_q", W'(regwrite_q), 32'h0);

        for (int k = 0; k < 7; k++) begin
            drive(1'b1, tbl_instr[k], tbl_rs[k], tbl_rt[k]);
            after_edge();
            check($sformatf("tbl%0d_result", k), result_q, tbl_res[k]);
        end

        drive(1'b1, itype(6'b100011, 16'h0004), 32'h200, 32'h0);
        after_edge();
        check("pre_rst_result", result_q, 32'h204);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_result", result_q, 32'h0);
        check("midrst_memread_q", W'(memread_q), 32'h0);
        check("midrst_regwrite_q", W'(regwrite_q), 32'h0);
        check("midrst_out_valid", W'(out_valid), 32'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        after_edge();
        check("post_rst_result", result_q, 32'h204);
        check("post_rst_memread_q", W'(memread_q), 32'h1);

        drive(1'b1, rtype(6'b100111), 32'h0, 32'h0);
        after_edge();
`ifdef EXEC_NOR_EN
        check("nor_result", result_q, 32'hFFFFFFFF);
`else
        check("nor_result", result_q, 32'h0);
`endif

        drive(1'b0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
